// File: rtl/cascade_if.sv
// Bundle between the cascade controller, its classifier stages and the result consumer.
interface cascade_if #(
    parameter int unsigned NUM_STAGES          = 2,
    parameter int unsigned DECISION_FUNCT_SIZE = 56,
    parameter int unsigned IDX_W               = 4
);
    logic                                          en;
    logic [NUM_STAGES*(DECISION_FUNCT_SIZE-1)-1:0] thresholds;
    logic [NUM_STAGES-1:0]                         stage_start;
    logic [NUM_STAGES-1:0]                         stage_done;
    logic [NUM_STAGES*DECISION_FUNCT_SIZE-1:0]     decision_in;
    logic [IDX_W-1:0]                              vec_idx;
    logic                                          result_valid;
    logic                                          result_ready;
    logic                                          y_class;
    logic [1:0]                                    stage_used;
    logic                                          busy;
    logic                                          run_done;

    modport master (
        output en, thresholds, stage_done, decision_in, result_ready,
        input  stage_start, vec_idx, result_valid, y_class, stage_used, busy, run_done
    );

    modport slave (
        input  en, thresholds, stage_done, decision_in, result_ready,
        output stage_start, vec_idx, result_valid, y_class, stage_used, busy, run_done
    );
endinterface

// File: rtl/cascade_ctrl.sv
// Early-exit cascade controller: runs each vector through stages until one is confident enough.
// Optional per-stage exit statistics are enabled with macro CASCADE_STATS_EN.
module cascade_ctrl #(
    parameter int unsigned NUM_STAGES          = 2,
    parameter int unsigned DECISION_FUNCT_SIZE = 56,
    parameter int unsigned NUM_OF_TEST_VECTORS = 10,
    parameter int unsigned IDX_W               = 4
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef CASCADE_STATS_EN
    output logic [NUM_STAGES*IDX_W-1:0] exit_count,
`endif
    cascade_if.slave                    bus
);
    localparam int unsigned DW = DECISION_FUNCT_SIZE;
    localparam int unsigned MW = DECISION_FUNCT_SIZE - 1;
    localparam int unsigned SW = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam logic [SW-1:0]    LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] LAST_VEC   = IDX_W'(NUM_OF_TEST_VECTORS - 1);

    logic [2:0]            r_state,        w_state_nxt;
    logic [SW-1:0]         r_stage,        w_stage_nxt;
    logic [IDX_W-1:0]      r_vec_idx,      w_vec_idx_nxt;
    logic [DW-1:0]         r_decision,     w_decision_nxt;
    logic [NUM_STAGES-1:0] r_stage_start,  w_stage_start_nxt;
    logic                  r_result_valid, w_result_valid_nxt;
    logic                  r_y_class,      w_y_class_nxt;
    logic [1:0]            r_stage_used,   w_stage_used_nxt;
    logic                  r_busy,         w_busy_nxt;
    logic                  r_run_done,     w_run_done_nxt;

    logic                  w_done_sel;
    logic [DW-1:0]         w_dec_sel;
    logic [MW-1:0]         w_thr_sel;
    logic                  w_exit;
    logic                  w_accept;

    // Select the slices belonging to the stage currently in flight
    assign w_done_sel = |(bus.stage_done & (NUM_STAGES'(1) << r_stage));
    assign w_dec_sel  = DW'(bus.decision_in >> (32'(r_stage) * DW));
    assign w_thr_sel  = MW'(bus.thresholds >> (32'(r_stage) * MW));
    assign w_exit     = (r_decision[MW-1:0] >= w_thr_sel) || (r_stage == LAST_STAGE);
    assign w_accept   = r_result_valid & bus.result_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_stage_nxt        = r_stage;
        w_vec_idx_nxt      = r_vec_idx;
        w_decision_nxt     = r_decision;
        w_stage_start_nxt  = '0;
        w_result_valid_nxt = r_result_valid;
        w_y_class_nxt      = r_y_class;
        w_stage_used_nxt   = r_stage_used;
        w_busy_nxt         = r_busy;
        w_run_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    w_vec_idx_nxt     = '0;
                    w_stage_nxt       = '0;
                    w_busy_nxt        = 1'b1;
                    w_stage_start_nxt = NUM_STAGES'(1);
                    w_state_nxt       = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done_sel) begin
                    w_decision_nxt = w_dec_sel;
                    w_state_nxt    = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_exit) begin
                    w_result_valid_nxt = 1'b1;
                    w_y_class_nxt      = ~r_decision[DW-1];
                    w_stage_used_nxt   = r_stage;
                    w_state_nxt        = S_OUT;
                end else begin
                    // Not confident enough: escalate to the next stage
                    w_stage_nxt       = r_stage + SW'(1);
                    w_stage_start_nxt = NUM_STAGES'(1) << (r_stage + SW'(1));
                    w_state_nxt       = S_START;
                end
            end
            S_OUT: begin
                if (w_accept) begin
                    w_result_valid_nxt = 1'b0;
                    if (r_vec_idx == LAST_VEC) begin
                        w_run_done_nxt = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_vec_idx_nxt     = r_vec_idx + IDX_W'(1);
                        w_stage_nxt       = '0;
                        w_stage_start_nxt = NUM_STAGES'(1);
                        w_state_nxt       = S_START;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_stage        <= '0;
            r_vec_idx      <= '0;
            r_decision     <= '0;
            r_stage_start  <= '0;
            r_result_valid <= 1'b0;
            r_y_class      <= 1'b0;
            r_stage_used   <= '0;
            r_busy         <= 1'b0;
            r_run_done     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_stage        <= w_stage_nxt;
            r_vec_idx      <= w_vec_idx_nxt;
            r_decision     <= w_decision_nxt;
            r_stage_start  <= w_stage_start_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_y_class      <= w_y_class_nxt;
            r_stage_used   <= w_stage_used_nxt;
            r_busy         <= w_busy_nxt;
            r_run_done     <= w_run_done_nxt;
        end
    end

    assign bus.stage_start  = r_stage_start;
    assign bus.vec_idx      = r_vec_idx;
    assign bus.result_valid = r_result_valid;
    assign bus.y_class      = r_y_class;
    assign bus.stage_used   = r_stage_used;
    assign bus.busy         = r_busy;
    assign bus.run_done     = r_run_done;

`ifdef CASCADE_STATS_EN
    logic [NUM_STAGES*IDX_W-1:0] r_exit_count, w_exit_count_nxt;

    // Saturating per-stage exit counters, cleared when a run starts
    always_comb begin
        w_exit_count_nxt = r_exit_count;
        if (r_state == S_IDLE && bus.en) begin
            w_exit_count_nxt = '0;
        end else if (r_state == S_OUT && w_accept) begin
            for (int s = 0; s < int'(NUM_STAGES); s++) begin
                if (r_stage_used == SW'(s) && r_exit_count[s*IDX_W +: IDX_W] != '1) begin
                    w_exit_count_nxt[s*IDX_W +: IDX_W] = r_exit_count[s*IDX_W +: IDX_W] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_exit_count <= '0;
        else     r_exit_count <= w_exit_count_nxt;
    end

    assign exit_count = r_exit_count;
`endif
endmodule
